lc_transition_arbiter: RTL

- Shares one lifecycle_protection instance among NUM_REQ requesters, e.g. debug port, secure firmware and manufacturing tester.
- Drives the `lc_transition_request`/`lc_identifier` handshake and waits for `lc_done` and `lc_success`.
- Returns a per-requester status. Adds round-robin fairness, a no-response timeout and end-of-life rejection.

---
 rtl/lc_transition_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/lc_transition_arbiter.sv
// Round-robin arbiter sharing one lifecycle_protection port among NUM_REQ requesters.
// Optional LC_ARB_LOCKOUT_EN adds a per-requester lockout after three authentication failures.
module lc_transition_arbiter #(
  parameter int         NUM_REQ        = 4,
  parameter int         ID_WIDTH       = 256,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [2:0] LC_EOL_STATE   = 3'd6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ID_WIDTH-1:0]  req_identifier,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [1:0]                   resp_status,
  output logic                         lc_transition_request,
  output logic [ID_WIDTH-1:0]          lc_identifier,
  input  logic                         lc_done,
  input  logic                         lc_success,
  input  logic [2:0]                   lc_state,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_idx
);

  localparam int IdxW = $clog2(NUM_REQ);
  localparam int CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] StOk      = 2'b00;
  localparam logic [1:0] StAuth    = 2'b01;
  localparam logic [1:0] StTimeout = 2'b10;
  localparam logic [1:0] StReject  = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESPOND} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     rrPtr_q;
  logic [IdxW-1:0]     grantIdx_q;
  logic [CntW-1:0]     cnt_q;
  logic [1:0]          status_q;
  logic                reqOut_q;
  logic [ID_WIDTH-1:0] ident_q;
  logic [NUM_REQ-1:0]  resp_q;

  logic                pickValid_d;
  logic [IdxW-1:0]     pickIdx_d;
  logic [IdxW:0]       candSum;
  logic [IdxW-1:0]     rrNext_d;
  logic                pickLocked_d;

  // First requesting index at or after rrPtr_q, wrapping modulo NUM_REQ.
  always_comb begin
    pickValid_d = 1'b0;
    pickIdx_d   = '0;
    candSum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      candSum = {1'b0, rrPtr_q} + (IdxW+1)'(k);
      if (candSum >= (IdxW+1)'(NUM_REQ)) candSum = candSum - (IdxW+1)'(NUM_REQ);
      if (!pickValid_d && req_valid[candSum[IdxW-1:0]]) begin
        pickValid_d = 1'b1;
        pickIdx_d   = candSum[IdxW-1:0];
      end
    end
    rrNext_d = (pickIdx_d == IdxW'(NUM_REQ - 1)) ? '0 : pickIdx_d + 1'b1;
  end

`ifdef LC_ARB_LOCKOUT_EN
  logic [1:0] failCnt_q [NUM_REQ];

  assign pickLocked_d = (failCnt_q[pickIdx_d] == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) failCnt_q[i] <= 2'd0;
    end else if (state_q == ISSUE && lc_done) begin
      if (lc_success) failCnt_q[grantIdx_q] <= 2'd0;
      else if (failCnt_q[grantIdx_q] != 2'd3) failCnt_q[grantIdx_q] <= failCnt_q[grantIdx_q] + 2'd1;
    end
  end
`else
  assign pickLocked_d = 1'b0;
`endif

  // Reset drops the downstream request and discards any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      grantIdx_q <= '0;
      cnt_q      <= '0;
      status_q   <= StOk;
      reqOut_q   <= 1'b0;
      ident_q    <= '0;
      resp_q     <= '0;
    end else begin
      resp_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (pickValid_d) begin
            grantIdx_q <= pickIdx_d;
            rrPtr_q    <= rrNext_d;
            ident_q    <= req_identifier[pickIdx_d*ID_WIDTH +: ID_WIDTH];
            if (lc_state == LC_EOL_STATE || pickLocked_d) begin
              status_q <= StReject;
              resp_q   <= NUM_REQ'(1) << pickIdx_d;
              state_q  <= RESPOND;
            end else begin
              reqOut_q <= 1'b1;
              state_q  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (lc_done) begin
            status_q <= lc_success ? StOk : StAuth;
            reqOut_q <= 1'b0;
            state_q  <= RELEASE;
          end else if (cnt_q == CntLast) begin
            status_q <= StTimeout;
            reqOut_q <= 1'b0;
            state_q  <= RELEASE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (!lc_done) begin
            resp_q  <= NUM_REQ'(1) << grantIdx_q;
            state_q <= RESPOND;
          end
        end
        RESPOND: begin
          cnt_q   <= '0;
          ident_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid            = resp_q;
  assign resp_status           = status_q;
  assign lc_transition_request = reqOut_q;
  assign lc_identifier         = ident_q;
  assign busy                  = (state_q != IDLE);
  assign grant_idx             = grantIdx_q;

endmodule
